// File: rtl/alu_issue_ctrl.sv
// In-order issue controller between register read and a variable-latency ALU.
// Optional feature: define ALU_ISSUE_BYPASS_EN for zero-latency issue when idle and empty.

package alu_issue_pkg;

  typedef struct packed {
    logic       valid;
    logic [2:0] unit_sel;
  } fur_sig_t;

  typedef struct packed {
    fur_sig_t    fur_sig;
    logic [3:0]  alu_op;
    logic [4:0]  rd;
    logic [15:0] opa;
    logic [15:0] opb;
  } reg_to_alu_req_t;

  typedef struct packed {
    fur_sig_t    fur_sig;
    logic [4:0]  rd;
    logic [15:0] result;
  } alu_to_wb_req_t;

endpackage

module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  reg_to_alu_req_t in_req,
  output logic            alu_start,
  output reg_to_alu_req_t alu_req,
  output logic            alu_kill,
  input  logic            alu_done,
  input  alu_to_wb_req_t  alu_res,
  output logic            wb_valid,
  input  logic            wb_ready,
  output alu_to_wb_req_t  wb_req,
  input  logic            flush,
  output logic            busy,
  output logic            err_timeout,
  output logic            err_spurious,
  output logic [1:0]      dbg_state
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Handshakes: a transfer happens on a cycle where valid and ready are both
  // high at the clock edge; valid never depends combinationally on ready.
  state_t          state_q, state_d;
  reg_to_alu_req_t mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  logic fifo_empty;
  logic bypass;
  logic push;
  logic pop;
  logic capture;
  logic wb_clear;
  logic set_tmo;
  logic set_spur;

  assign fifo_empty = (count_q == '0);
  assign in_ready   = (count_q < CNT_W'(DEPTH)) && !flush;

`ifdef ALU_ISSUE_BYPASS_EN
  assign bypass = (state_q == IDLE) && fifo_empty && in_valid && !flush;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed request goes straight to the ALU and never occupies a slot.
  assign push      = in_valid && in_ready && !bypass;
  assign busy      = (state_q != IDLE) || !fifo_empty;
  assign dbg_state = state_q;

  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    alu_start = 1'b0;
    alu_req   = mem[rd_ptr_q];
    alu_kill  = 1'b0;
    pop       = 1'b0;
    capture   = 1'b0;
    wb_clear  = 1'b0;
    set_tmo   = 1'b0;
    set_spur  = 1'b0;

    if (flush) begin
      // A result returning in the flush cycle is squashed with everything else.
      state_d  = IDLE;
      tmo_d    = '0;
      alu_kill = (state_q == EXEC);
      wb_clear = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          set_spur = alu_done;
          if (bypass) begin
            alu_start = 1'b1;
            alu_req   = in_req;
            state_d   = EXEC;
            tmo_d     = '0;
          end else if (!fifo_empty) begin
            alu_start = 1'b1;
            pop       = 1'b1;
            state_d   = EXEC;
            tmo_d     = '0;
          end
        end
        EXEC: begin
          tmo_d = tmo_q + TMO_W'(1);
          if (alu_done) begin
            capture = 1'b1;
            state_d = HOLD;
            tmo_d   = '0;
          end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
            alu_kill = 1'b1;
            set_tmo  = 1'b1;
            state_d  = IDLE;
            tmo_d    = '0;
          end
        end
        HOLD: begin
          set_spur = alu_done;
          if (wb_ready) begin
            wb_clear = 1'b1;
            if (!fifo_empty) begin
              alu_start = 1'b1;
              pop       = 1'b1;
              state_d   = EXEC;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: begin
          state_d = IDLE;
          tmo_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage has no reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= in_req;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid <= 1'b0;
      wb_req   <= '0;
    end else if (capture) begin
      wb_valid <= 1'b1;
      wb_req   <= alu_res;
    end else if (wb_clear) begin
      wb_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_timeout  <= 1'b0;
      err_spurious <= 1'b0;
    end else begin
      if (set_tmo)  err_timeout  <= 1'b1;
      if (set_spur) err_spurious <= 1'b1;
    end
  end

  a_no_start_in_exec : assert property (@(posedge clk) disable iff (rst)
    !(alu_start && (state_q == EXEC)));
  a_start_kill_excl : assert property (@(posedge clk) disable iff (rst)
    !(alu_start && alu_kill));
  a_count_bound : assert property (@(posedge clk) disable iff (rst)
    count_q <= CNT_W'(DEPTH));
  a_wb_valid_hold : assert property (@(posedge clk) disable iff (rst)
    wb_valid == (state_q == HOLD));

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomised and directed bench for alu_issue_ctrl with a transaction-level reference model.
module tb_alu_issue_ctrl;
  import alu_issue_pkg::*;

  localparam int DEPTH = 4;
  localparam int TMO   = 64;
  localparam int REQ_W = $bits(reg_to_alu_req_t);
  localparam int RES_W = $bits(alu_to_wb_req_t);

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  reg_to_alu_req_t in_req;
  logic            alu_start;
  reg_to_alu_req_t alu_req;
  logic            alu_kill;
  logic            alu_done;
  alu_to_wb_req_t  alu_res;
  logic            wb_valid;
  logic            wb_ready;
  alu_to_wb_req_t  wb_req;
  logic            flush;
  logic            busy;
  logic            err_timeout;
  logic            err_spurious;
  logic [1:0]      dbg_state;

  logic [REQ_W-1:0] alu_req_bits;
  logic [RES_W-1:0] wb_req_bits;
  assign alu_req_bits = alu_req;
  assign wb_req_bits  = wb_req;

  alu_issue_ctrl #(.DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_req(in_req),
    .alu_start(alu_start), .alu_req(alu_req), .alu_kill(alu_kill),
    .alu_done(alu_done), .alu_res(alu_res),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_req(wb_req),
    .flush(flush), .busy(busy),
    .err_timeout(err_timeout), .err_spurious(err_spurious),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model state ----------------
  int vectors;
  int miscompares;
  logic [REQ_W-1:0] req_q[$];   // accepted, not yet issued
  logic [RES_W-1:0] exp_q[$];   // result expected on the writeback port
  bit in_flight;
  bit holding;
  int exec_age;
  bit exp_err_tmo;
  bit exp_err_spur;
  int cyc;
  int done_at;
  bit auto_alu;

  bit seen_ready, seen_start, seen_kill, seen_wbv, seen_busy;
  logic [RES_W-1:0] seen_wbreq;

  function automatic logic [REQ_W-1:0] rnd_req();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[REQ_W-1:0];
  endfunction

  function automatic logic [RES_W-1:0] rnd_res();
    logic [31:0] t;
    t = $urandom();
    return t[RES_W-1:0];
  endfunction

  task automatic model_clear();
    req_q.delete();
    exp_q.delete();
    in_flight    = 0;
    holding      = 0;
    exec_age     = 0;
    exp_err_tmo  = 0;
    exp_err_spur = 0;
    auto_alu     = 0;
  endtask

  task automatic apply_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_req   = '0;
    wb_ready = 1'b0;
    alu_done = 1'b0;
    alu_res  = '0;
    flush    = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
  endtask

  // ---------------- driver + scoreboard for one clock cycle ----------------
  task automatic drive_cycle(input logic iv, input logic [REQ_W-1:0] rq, input logic wr,
                             input logic dn, input logic [RES_W-1:0] rs, input logic fl);
    logic d, exp_ready, exp_start, exp_kill, exp_busy, byp;
    logic [REQ_W-1:0] exp_req;
    d = auto_alu ? (in_flight && (cyc == done_at)) : dn;
    in_valid = iv;
    in_req   = rq;
    wb_ready = wr;
    alu_done = d;
    alu_res  = rs;
    flush    = fl;
    @(negedge clk);

    exp_ready = (req_q.size() < DEPTH) && !fl;
    byp = 1'b0;
`ifdef ALU_ISSUE_BYPASS_EN
    byp = !fl && !in_flight && !holding && (req_q.size() == 0) && iv;
`endif
    exp_start = !fl && !in_flight && (byp || ((req_q.size() != 0) && (!holding || wr)));
    exp_req   = byp ? rq : ((req_q.size() != 0) ? req_q[0] : '0);
    exp_kill  = fl ? in_flight : (in_flight && !d && (exec_age + 1 == TMO));
    exp_busy  = in_flight || holding || (req_q.size() != 0);

    vectors++;
    if (in_ready !== exp_ready) begin
      miscompares++;
      $display("FAIL in_ready cyc=%0d got %b want %b", cyc, in_ready, exp_ready);
    end
    vectors++;
    if (alu_start !== exp_start) begin
      miscompares++;
      $display("FAIL alu_start cyc=%0d got %b want %b", cyc, alu_start, exp_start);
    end
    if (exp_start) begin
      vectors++;
      if (alu_req_bits !== exp_req) begin
        miscompares++;
        $display("FAIL alu_req cyc=%0d got %h want %h", cyc, alu_req_bits, exp_req);
      end
    end
    vectors++;
    if (alu_kill !== exp_kill) begin
      miscompares++;
      $display("FAIL alu_kill cyc=%0d got %b want %b", cyc, alu_kill, exp_kill);
    end
    vectors++;
    if (wb_valid !== holding) begin
      miscompares++;
      $display("FAIL wb_valid cyc=%0d got %b want %b", cyc, wb_valid, holding);
    end
    if (holding) begin
      vectors++;
      if (wb_req_bits !== exp_q[0]) begin
        miscompares++;
        $display("FAIL wb_req cyc=%0d got %h want %h", cyc, wb_req_bits, exp_q[0]);
      end
    end
    vectors++;
    if (busy !== exp_busy) begin
      miscompares++;
      $display("FAIL busy cyc=%0d got %b want %b", cyc, busy, exp_busy);
    end
    vectors++;
    if (err_timeout !== exp_err_tmo) begin
      miscompares++;
      $display("FAIL err_timeout cyc=%0d got %b want %b", cyc, err_timeout, exp_err_tmo);
    end
    vectors++;
    if (err_spurious !== exp_err_spur) begin
      miscompares++;
      $display("FAIL err_spurious cyc=%0d got %b want %b", cyc, err_spurious, exp_err_spur);
    end

    seen_ready = in_ready;
    seen_start = alu_start;
    seen_kill  = alu_kill;
    seen_wbv   = wb_valid;
    seen_busy  = busy;
    seen_wbreq = wb_req_bits;

    if (fl) begin
      req_q.delete();
      exp_q.delete();
      in_flight = 0;
      holding   = 0;
      exec_age  = 0;
    end else begin
      if (!in_flight && d) exp_err_spur = 1;
      if (holding && wr) begin
        void'(exp_q.pop_front());
        holding = 0;
      end
      if (in_flight) begin
        if (d) begin
          exp_q.push_back(rs);
          holding   = 1;
          in_flight = 0;
          exec_age  = 0;
        end else if (exec_age + 1 == TMO) begin
          exp_err_tmo = 1;
          in_flight   = 0;
          exec_age    = 0;
        end else begin
          exec_age++;
        end
      end
      if (exp_start) begin
        if (!byp) void'(req_q.pop_front());
        in_flight = 1;
        exec_age  = 0;
        done_at   = cyc + int'($urandom_range(1, 6));
      end
      if (iv && exp_ready && !byp) req_q.push_back(rq);
    end
    cyc++;
    @(posedge clk); #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1 || alu_start !== 1'b0 || alu_kill !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctl got ready=%b start=%b kill=%b want 1 0 0", in_ready, alu_start, alu_kill);
    end
    vectors++;
    if (wb_valid !== 1'b0 || wb_req_bits !== '0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_wb got wbv=%b wbreq=%h busy=%b want 0 0 0", wb_valid, wb_req_bits, busy);
    end
    vectors++;
    if (err_timeout !== 1'b0 || err_spurious !== 1'b0 || dbg_state !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_err got tmo=%b spur=%b st=%0d want 0 0 0", err_timeout, err_spurious, dbg_state);
    end
    apply_reset();
  endtask

  task automatic test_single_op();
    bit s0, s1;
    logic [RES_W-1:0] res;
    apply_reset();
    res = rnd_res();
    drive_cycle(1, rnd_req(), 1, 0, '0, 0);  s0 = seen_start;
    drive_cycle(0, '0, 1, 0, '0, 0);         s1 = seen_start;
    drive_cycle(0, '0, 1, 0, '0, 0);
    drive_cycle(0, '0, 1, 0, '0, 0);
    drive_cycle(0, '0, 1, 1, res, 0);
    drive_cycle(0, '0, 1, 0, '0, 0);
    vectors++;
    if (seen_wbv !== 1'b1 || seen_wbreq !== res) begin
      miscompares++;
      $display("FAIL single_wb got v=%b d=%h want 1 %h", seen_wbv, seen_wbreq, res);
    end
    drive_cycle(0, '0, 1, 0, '0, 0);
    vectors++;
    if (seen_busy !== 1'b0 || seen_wbv !== 1'b0) begin
      miscompares++;
      $display("FAIL single_idle got busy=%b wbv=%b want 0 0", seen_busy, seen_wbv);
    end
    vectors++;
`ifdef ALU_ISSUE_BYPASS_EN
    if (s0 !== 1'b1 || s1 !== 1'b0) begin
`else
    if (s0 !== 1'b0 || s1 !== 1'b1) begin
`endif
      miscompares++;
      $display("FAIL single_latency got start t0=%b t1=%b", s0, s1);
    end
  endtask

  task automatic test_back_to_back();
    int acc, starts;
    bit iv;
    apply_reset();
    acc = 0;
    starts = 0;
    for (int k = 0; k < 8; k++) begin
      iv = (acc < 6);
      drive_cycle(iv, rnd_req(), 0, (k == 3), rnd_res(), 0);
      if (iv && seen_ready) acc++;
      if (seen_start) starts++;
    end
    vectors++;
    if (acc !== 5 || starts !== 1 || seen_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL backpressure got acc=%0d starts=%0d ready=%b want 5 1 0", acc, starts, seen_ready);
    end
    auto_alu = 1;
    for (int k = 0; k < 80; k++) begin
      iv = (acc < 6);
      drive_cycle(iv, rnd_req(), 1, 0, rnd_res(), 0);
      if (iv && seen_ready) acc++;
      if (seen_start) starts++;
    end
    auto_alu = 0;
    vectors++;
    if (acc !== 6 || starts !== 6 || seen_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL drain got acc=%0d starts=%0d busy=%b want 6 6 0", acc, starts, seen_busy);
    end
  endtask

  task automatic test_timeout();
    int nstart, st1, st2, kill_k, nwb;
    bit dn;
    apply_reset();
    nstart = 0; st1 = -1000; st2 = 1000; kill_k = -1; nwb = 0;
    for (int k = 0; k < 100; k++) begin
      dn = (nstart == 2) && (k == st2 + 3);
      drive_cycle(k < 2, rnd_req(), 1, dn, rnd_res(), 0);
      if (seen_start) begin
        nstart++;
        if (nstart == 1) st1 = k; else st2 = k;
      end
      if (seen_kill) kill_k = k;
      if (seen_wbv) nwb++;
    end
    vectors++;
    if (kill_k - st1 !== TMO) begin
      miscompares++;
      $display("FAIL timeout_kill got %0d cycles want %0d", kill_k - st1, TMO);
    end
    vectors++;
    if (nstart !== 2 || st2 <= kill_k || nwb !== 1 || err_timeout !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_after got starts=%0d wbs=%0d err=%b want 2 1 1", nstart, nwb, err_timeout);
    end
  endtask

  task automatic test_flush();
    apply_reset();
    drive_cycle(1, rnd_req(), 1, 0, '0, 0);
    drive_cycle(1, rnd_req(), 1, 0, '0, 0);
    drive_cycle(1, rnd_req(), 1, 0, '0, 0);
    drive_cycle(0, '0, 1, 1, rnd_res(), 1);
    vectors++;
    if (seen_kill !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_kill got %b want 1", seen_kill);
    end
    drive_cycle(0, '0, 1, 0, '0, 0);
    vectors++;
    if (seen_busy !== 1'b0 || seen_wbv !== 1'b0 || seen_start !== 1'b0 || err_spurious !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_after got busy=%b wbv=%b start=%b spur=%b want 0 0 0 0",
               seen_busy, seen_wbv, seen_start, err_spurious);
    end
  endtask

  task automatic test_spurious();
    apply_reset();
    drive_cycle(0, '0, 1, 1, rnd_res(), 0);
    drive_cycle(0, '0, 1, 0, '0, 0);
    drive_cycle(0, '0, 1, 0, '0, 0);
    vectors++;
    if (err_spurious !== 1'b1 || seen_wbv !== 1'b0) begin
      miscompares++;
      $display("FAIL spurious got err=%b wbv=%b want 1 0", err_spurious, seen_wbv);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    drive_cycle(1, rnd_req(), 0, 0, '0, 0);
    drive_cycle(1, rnd_req(), 0, 0, '0, 0);
    drive_cycle(1, rnd_req(), 0, 0, '0, 0);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    vectors++;
    if (alu_kill !== 1'b0 || busy !== 1'b0 || wb_valid !== 1'b0 || in_ready !== 1'b1 || alu_start !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid got kill=%b busy=%b wbv=%b ready=%b start=%b want 0 0 0 1 0",
               alu_kill, busy, wb_valid, in_ready, alu_start);
    end
    apply_reset();
  endtask

  task automatic test_random();
    int starts;
    apply_reset();
    auto_alu = 1;
    starts = 0;
    for (int k = 0; k < 400; k++) begin
      drive_cycle($urandom_range(0, 9) < 7, rnd_req(), $urandom_range(0, 9) < 6, 0,
                  rnd_res(), $urandom_range(0, 99) < 3);
      if (seen_start) starts++;
    end
    auto_alu = 0;
    vectors++;
    if (starts < 20) begin
      miscompares++;
      $display("FAIL random_progress got %0d issues want >= 20", starts);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    done_at     = 0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_req      = '0;
    wb_ready    = 1'b0;
    alu_done    = 1'b0;
    alu_res     = '0;
    flush       = 1'b0;
    model_clear();
    test_reset();
    test_single_op();
    test_back_to_back();
    test_timeout();
    test_flush();
    test_spurious();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
